boss_proj_scheduler: RTL and testbench



---
 rtl/boss_proj_scheduler.sv | 163 ++++++++++++++++
 tb/tb_boss_proj_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/boss_proj_scheduler.sv
// rtl/boss_proj_scheduler.sv - five-slot boss projectile allocator, mover and retirer
// Optional hit counter output enabled with BOSS_PROJ_HITCNT_EN.
module boss_proj_scheduler #(
    parameter int SCREEN_H       = 480,
    parameter int PROJ_SPEED     = 4,
    parameter int SPAWN_COOLDOWN = 30,
    parameter int PROJ_SIZE      = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       spawn_req,
    input  logic [9:0] spawn_x,
    input  logic [8:0] spawn_y,
    output logic       spawn_ack,
    input  logic       projHit,
    input  logic [2:0] collidedProj,
    output logic [9:0] bossProj1X,
    output logic [9:0] bossProj2X,
    output logic [9:0] bossProj3X,
    output logic [9:0] bossProj4X,
    output logic [9:0] bossProj5X,
    output logic [8:0] bossProj1Y,
    output logic [8:0] bossProj2Y,
    output logic [8:0] bossProj3Y,
    output logic [8:0] bossProj4Y,
    output logic [8:0] bossProj5Y,
    output logic [4:0] proj_active,
    output logic [9:0] projW
`ifdef BOSS_PROJ_HITCNT_EN
    ,
    output logic [7:0] hit_count
`endif
);

    localparam logic [9:0] PARK_X = 10'd1023;
    localparam logic [8:0] PARK_Y = 9'd511;

    logic [9:0]  posX [5];
    logic [8:0]  posY [5];
    logic [4:0]  active;
    logic [15:0] cooldown;

    logic [9:0]  nextX [5];
    logic [8:0]  nextY [5];
    logic [9:0]  yStep [5];
    logic [4:0]  nextActive;
    logic [15:0] nextCooldown;
    logic [4:0]  hitMask;
    logic [4:0]  allocOh;
    logic        spawnOk;
    logic        tickEn;

    assign tickEn = frame_tick && enable;

    // The ack is a decode of registered state and the live request so it lands in the request cycle.
    assign spawnOk = rst_n && spawn_req && enable && (cooldown == 16'd0) && !(&active);

    always_comb begin
        hitMask = '0;
        for (int i = 0; i < 5; i++) begin
            hitMask[i] = projHit && (collidedProj == 3'(i + 1));
        end
    end

    always_comb begin
        allocOh = '0;
        for (int i = 0; i < 5; i++) begin
            if (!active[i] && (allocOh == 5'd0)) begin
                allocOh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            yStep[i] = {1'b0, posY[i]} + 10'(PROJ_SPEED);
        end
    end

    // Per slot: hit retire beats movement; only a slot free at cycle start can take a spawn.
    always_comb begin
        nextActive = active;
        nextX      = posX;
        nextY      = posY;
        for (int i = 0; i < 5; i++) begin
            if (active[i]) begin
                if (hitMask[i]) begin
                    nextActive[i] = 1'b0;
                    nextX[i]      = PARK_X;
                    nextY[i]      = PARK_Y;
                end else if (tickEn) begin
                    if (yStep[i] >= 10'(SCREEN_H)) begin
                        nextActive[i] = 1'b0;
                        nextX[i]      = PARK_X;
                        nextY[i]      = PARK_Y;
                    end else begin
                        nextY[i] = yStep[i][8:0];
                    end
                end
            end else if (spawnOk && allocOh[i]) begin
                nextActive[i] = 1'b1;
                nextX[i]      = spawn_x;
                nextY[i]      = spawn_y;
            end
        end
    end

    always_comb begin
        nextCooldown = cooldown;
        if (spawnOk) begin
            nextCooldown = 16'(SPAWN_COOLDOWN);
        end else if (tickEn && (cooldown != 16'd0)) begin
            nextCooldown = cooldown - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= '0;
            cooldown <= '0;
            for (int i = 0; i < 5; i++) begin
                posX[i] <= PARK_X;
                posY[i] <= PARK_Y;
            end
        end else begin
            active   <= nextActive;
            cooldown <= nextCooldown;
            posX     <= nextX;
            posY     <= nextY;
        end
    end

`ifdef BOSS_PROJ_HITCNT_EN
    logic [7:0] hitCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hitCnt <= '0;
        end else if ((|(hitMask & active)) && (hitCnt != 8'd255)) begin
            hitCnt <= hitCnt + 8'd1;
        end
    end

    assign hit_count = hitCnt;
`endif

    assign spawn_ack   = spawnOk;
    assign proj_active = active;
    assign projW       = 10'(PROJ_SIZE);
    assign bossProj1X  = posX[0];
    assign bossProj2X  = posX[1];
    assign bossProj3X  = posX[2];
    assign bossProj4X  = posX[3];
    assign bossProj5X  = posX[4];
    assign bossProj1Y  = posY[0];
    assign bossProj2Y  = posY[1];
    assign bossProj3Y  = posY[2];
    assign bossProj4Y  = posY[3];
    assign bossProj5Y  = posY[4];

endmodule

// File: tb/tb_boss_proj_scheduler.sv
// tb/tb_boss_proj_scheduler.sv - scoreboard bench for boss_proj_scheduler
module tb_boss_proj_scheduler;

    localparam int SH    = 480;
    localparam int SPD   = 4;
    localparam int CD    = 3;
    localparam int PSIZE = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic       spawn_req = 1'b0;
    logic [9:0] spawn_x = '0;
    logic [8:0] spawn_y = '0;
    logic       spawn_ack;
    logic       projHit = 1'b0;
    logic [2:0] collidedProj = '0;
    logic [9:0] p1x, p2x, p3x, p4x, p5x, projW;
    logic [8:0] p1y, p2y, p3y, p4y, p5y;
    logic [4:0] proj_active;
`ifdef BOSS_PROJ_HITCNT_EN
    logic [7:0] hit_count;
`endif

    boss_proj_scheduler #(
        .SCREEN_H(SH), .PROJ_SPEED(SPD), .SPAWN_COOLDOWN(CD), .PROJ_SIZE(PSIZE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
        .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_ack(spawn_ack),
        .projHit(projHit), .collidedProj(collidedProj),
        .bossProj1X(p1x), .bossProj2X(p2x), .bossProj3X(p3x), .bossProj4X(p4x), .bossProj5X(p5x),
        .bossProj1Y(p1y), .bossProj2Y(p2y), .bossProj3Y(p3y), .bossProj4Y(p4y), .bossProj5Y(p5y),
        .proj_active(proj_active), .projW(projW)
`ifdef BOSS_PROJ_HITCNT_EN
        , .hit_count(hit_count)
`endif
    );

    always #5 clk = ~clk;

    logic [94:0] dutPos;
    assign dutPos = {p5x, p5y, p4x, p4y, p3x, p3y, p2x, p2y, p1x, p1y};

    typedef struct {
        logic        ack;
        logic [4:0]  act;
        logic [94:0] pos;
        logic [7:0]  hc;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nPass   = 0;

    // Reference model: plain per-slot integers.
    int mx[5];
    int my[5];
    bit ma[5];
    int mcd;
    int mhit;
    bit lastAck;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        nChecks++;
        if (act === expv) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 5; i++) begin
            mx[i] = 1023; my[i] = 511; ma[i] = 0;
        end
        mcd = 0;
        mhit = 0;
    endfunction

    function automatic exp_t snapshot(input bit ack);
        exp_t e;
        e.ack = ack;
        e.act = '0;
        e.pos = '0;
        for (int i = 0; i < 5; i++) begin
            e.act[i] = ma[i];
            e.pos[i*19 +: 19] = {10'(mx[i]), 9'(my[i])};
        end
        e.hc = 8'(mhit);
        return e;
    endfunction

    task automatic step(input bit req, input int x, input int y, input bit tick,
                        input bit en, input bit hit, input int cp);
        int  k;
        bit  ack;
        spawn_req = req; spawn_x = 10'(x); spawn_y = 9'(y);
        frame_tick = tick; enable = en; projHit = hit; collidedProj = 3'(cp);
        k = -1;
        for (int i = 4; i >= 0; i--) if (!ma[i]) k = i;
        ack = req && en && (mcd == 0) && (k >= 0);
        q.push_back(snapshot(ack));
        for (int i = 0; i < 5; i++) begin
            if (ma[i]) begin
                if (hit && cp == i + 1) begin
                    ma[i] = 0; mx[i] = 1023; my[i] = 511;
                    if (mhit < 255) mhit++;
                end else if (tick && en) begin
                    if (my[i] + SPD >= SH) begin
                        ma[i] = 0; mx[i] = 1023; my[i] = 511;
                    end else begin
                        my[i] = my[i] + SPD;
                    end
                end
            end else if (ack && i == k) begin
                ma[i] = 1; mx[i] = x; my[i] = y;
            end
        end
        if (ack) mcd = CD;
        else if (tick && en && mcd > 0) mcd--;
        lastAck = ack;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("ack", 128'(spawn_ack), 128'(e.ack));
            check("active", 128'(proj_active), 128'(e.act));
            check("pos", 128'(dutPos), 128'(e.pos));
`ifdef BOSS_PROJ_HITCNT_EN
            check("hitcnt", 128'(hit_count), 128'(e.hc));
`endif
        end
    end

    task automatic checkReset(input string tag);
        check({tag, "_active"}, 128'(proj_active), 128'(0));
        check({tag, "_ack"}, 128'(spawn_ack), 128'(0));
        check({tag, "_pos"}, 128'(dutPos), {33'd0, {5{10'd1023, 9'd511}}});
`ifdef BOSS_PROJ_HITCNT_EN
        check({tag, "_hitcnt"}, 128'(hit_count), 128'(0));
`endif
    endtask

    bit reqHeld;
    int hx, hy;

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        check("projW", 128'(projW), 128'(PSIZE));
        rst_n = 1'b1;

        // First spawn, then drive slot 1 across the bottom edge.
        step(1, 200, 210, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b0; #1; rst_n = 1'b1; modelReset();
        step(1, 50, 470, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 0);

        // Fill all slots, hold a sixth request, then free slot 3 by a hit.
        for (int i = 0; i < 20; i++) step(1, 10 * i, 100, (i % 4) != 3, 1, 0, 0);
        step(1, 999, 77, 0, 1, 0, 0);
        step(1, 999, 77, 0, 1, 1, 3);
        for (int i = 0; i < 6; i++) step(1, 999, 77, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 1, 2);
        step(0, 0, 0, 0, 1, 1, 6);
        step(0, 0, 0, 0, 1, 1, 2);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 5, 5, 1, 0, 0, 0);

        // Random phase with a well-behaved requester and one mid-run reset.
        reqHeld = 0; hx = 0; hy = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                spawn_req = 1'b1; enable = 1'b1;
                rst_n = 1'b0; #1;
                checkReset("midreset");
                @(posedge clk); #1;
                rst_n = 1'b1;
                modelReset();
                reqHeld = 0;
            end
            if (!reqHeld && $urandom_range(0, 3) == 0) begin
                reqHeld = 1;
                hx = int'($urandom_range(0, 1023));
                hy = int'($urandom_range(0, 479));
            end
            step(reqHeld, hx, hy, $urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 5) == 0, int'($urandom_range(0, 7)));
            if (lastAck) reqHeld = 0;
        end

        step(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk); #1;
        check("drain", 128'(q.size()), 128'(0));
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
